// File: rtl/mips_div_ctrl.sv
// Multi-cycle divide controller for the MIPS Harvard CPU.
// Sequences a radix-2 restoring divider for DIV/DIVU, owns the HI/LO
// registers (including MTHI/MTLO writes) and raises a pipeline stall
// whenever the CPU touches HI/LO or starts a divide while one is running.
module mips_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             read_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PREP  = 2'd1;
  localparam logic [1:0] S_ITER  = 2'd2;
  localparam logic [1:0] S_FIXUP = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dvsr_raw;
  logic [WIDTH-1:0] dvsr_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sgn;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  // The next partial remainder candidate: shift in the top quotient bit and
  // try subtracting the divisor magnitude one bit wider so the borrow shows.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvsr_mag};

  // Anything other than IDLE means a divide owns HI/LO; requests must wait.
  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | mthi | mtlo | read_hilo);

  // Divider sequencing and HI/LO ownership; clk_enable low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      counter  <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dvd_raw  <= '0;
      dvsr_raw <= '0;
      dvsr_mag <= '0;
      rem      <= '0;
      quo      <= '0;
      sgn      <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else if (clk_enable) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mthi) hi <= mt_data;
          if (mtlo) lo <= mt_data;
          if (start) begin
            dvd_raw  <= dividend;
            dvsr_raw <= divisor;
            sgn      <= op_signed;
            state    <= S_PREP;
          end
        end
        S_PREP: begin
          quo      <= (sgn & dvd_raw[WIDTH-1])  ? -dvd_raw  : dvd_raw;
          dvsr_mag <= (sgn & dvsr_raw[WIDTH-1]) ? -dvsr_raw : dvsr_raw;
          rem      <= '0;
          q_neg    <= sgn & (dvd_raw[WIDTH-1] ^ dvsr_raw[WIDTH-1]);
          r_neg    <= sgn & dvd_raw[WIDTH-1];
          if (dvsr_raw == '0) begin
            state <= S_FIXUP;
          end else begin
            state   <= S_ITER;
            counter <= CW'(WIDTH - 1);
          end
        end
        S_ITER: begin
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          if (!trial[WIDTH]) rem <= trial[WIDTH-1:0];
          else               rem <= rem_shift[WIDTH-1:0];
          if (counter == '0) state <= S_FIXUP;
          else               counter <= counter - 1'b1;
        end
        S_FIXUP: begin
          if (dvsr_raw == '0) begin
            hi <= dvd_raw;
            lo <= '1;
          end else begin
            hi <= r_neg ? -rem : rem;
            lo <= q_neg ? -quo : quo;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_ctrl.sv
// Self-checking bench for mips_div_ctrl: a table of divide vectors plus
// hand-written sequences for stalls, reset mid-divide and clock-enable freeze.
module tb_mips_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic        op_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        read_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[8];

  mips_div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op_signed  (op_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .mt_data    (mt_data),
    .read_hilo  (read_hilo),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .stall      (stall)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a divide request for exactly one edge.
  task automatic apply_stimulus(input logic sgn, input logic [31:0] a,
                                input logic [31:0] b);
    start     = 1'b1;
    op_signed = sgn;
    dividend  = a;
    divisor   = b;
    tick();
    start     = 1'b0;
  endtask

  // Wait (bounded) for done; returns edges counted after the start edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat,
                         input string name);
    int cyc;
    apply_stimulus(sgn, a, b);
    check_output({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check_output({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_output({name, "_lo"}, lo, exp_lo);
    check_output({name, "_hi"}, hi, exp_hi);
    tick();
    check_output({name, "_done_pulse"}, 32'(done), 32'd0);
    check_output({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  cyc;
    logic stall_ok;

    vecs[0] = '{1'b0, 32'h0000004D, 32'h0000000B, 32'h00000007, 32'h00000000, 34, "divu_77_11"};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, "div_m7_2"};
    vecs[2] = '{1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001, 34, "divu_fff9_2"};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 34, "div_ovf"};
    vecs[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, "divu_big"};
    vecs[5] = '{1'b0, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 2,  "divu_by0"};
    vecs[6] = '{1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 2,  "div_by0"};
    vecs[7] = '{1'b1, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 34, "div_100_m7"};

    reset      = 1'b0;
    clk_enable = 1'b1;
    start      = 1'b0;
    op_signed  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    mthi       = 1'b0;
    mtlo       = 1'b0;
    mt_data    = '0;
    read_hilo  = 1'b0;

    tick();
    tick();
    check_output("reset_hi", hi, 32'h0);
    check_output("reset_lo", lo, 32'h0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // MTHI and MTLO together in IDLE write both registers; MFHI never stalls.
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h00005A5A; read_hilo = 1'b1;
    #1;
    check_output("idle_read_stall", 32'(stall), 32'd0);
    tick();
    mthi = 1'b0; mtlo = 1'b0; read_hilo = 1'b0;
    check_output("mt_both_hi", hi, 32'h00005A5A);
    check_output("mt_both_lo", lo, 32'h00005A5A);

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_lo,
              vecs[i].exp_hi, vecs[i].exp_lat, vecs[i].name);
    end

    // Start together with MTHI: MT write lands first, divide result later.
    mthi = 1'b1; mt_data = 32'h0000BEEF;
    apply_stimulus(1'b0, 32'd100, 32'd7);
    mthi = 1'b0;
    check_output("start_mthi_hi", hi, 32'h0000BEEF);
    wait_done(cyc);
    check_output("start_mthi_lat", 32'(cyc), 32'd34);
    check_output("start_mthi_lo_res", lo, 32'd14);
    check_output("start_mthi_hi_res", hi, 32'd2);
    tick();

    // MFHI + MTHI held from cycle 5 of a divide: stall until busy falls.
    apply_stimulus(1'b0, 32'h0000004D, 32'h0000000B);
    for (int i = 1; i < 5; i++) tick();
    read_hilo = 1'b1; mthi = 1'b1; mt_data = 32'h00001234;
    #1;
    stall_ok = 1'b1;
    cyc = 0;
    while (busy && cyc < 200) begin
      if (!stall) stall_ok = 1'b0;
      tick();
      cyc++;
    end
    check_output("held_stall_while_busy", 32'(stall_ok), 32'd1);
    check_output("held_stall_drop", 32'(stall), 32'd0);
    check_output("held_done", 32'(done), 32'd1);
    check_output("held_hi_result", hi, 32'h0);
    tick();
    read_hilo = 1'b0; mthi = 1'b0;
    check_output("held_hi_mthi", hi, 32'h00001234);
    check_output("held_lo_quo", lo, 32'd7);

    // Asynchronous reset during iteration 10 abandons the divide.
    mtlo = 1'b1; mt_data = 32'h0000AAAA;
    tick();
    mtlo = 1'b0;
    check_output("mtlo_aaaa", lo, 32'h0000AAAA);
    apply_stimulus(1'b0, 32'h0000004D, 32'h0000000B);
    for (int i = 0; i < 11; i++) tick();
    check_output("rst_pre_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_output("rst_async_busy", 32'(busy), 32'd0);
    check_output("rst_async_hi", hi, 32'h0);
    check_output("rst_async_lo", lo, 32'h0);
    #1 reset = 1'b1;
    tick();
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, "post_rst_divu");

    // Freeze the divide for 5 cycles with clk_enable low.
    apply_stimulus(1'b0, 32'h0000004D, 32'h0000000B);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc++;
    end
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cyc++;
      check_output("freeze_hi", hi, 32'd2);
      check_output("freeze_lo", lo, 32'd14);
      check_output("freeze_busy", 32'(busy), 32'd1);
    end
    clk_enable = 1'b1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check_output("freeze_latency", 32'(cyc), 32'd39);
    check_output("freeze_lo_res", lo, 32'd7);
    check_output("freeze_hi_res", hi, 32'd0);
    tick();
    check_output("freeze_done_pulse", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_div_ctrl.md
Name: mips_div_ctrl

Overview:
- Multi-cycle divide controller for the MIPS Harvard CPU.
- Sequences a radix-2 restoring divider for DIV and DIVU.
- Owns the architectural HI/LO registers and services MTHI and MTLO.
- Stalls the pipeline when the CPU touches HI/LO or issues a new divide while one is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clk_enable  input  1  when low, all state frozen (no transitions, no counter advance)
start  input  1  divide request from decode, one cycle
op_signed  input  1  1 = DIV, 0 = DIVU; sampled with start
dividend  input  WIDTH  rs value, sampled with start
divisor  input  WIDTH  rt value, sampled with start
mthi  input  1  write mt_data to HI
mtlo  input  1  write mt_data to LO
mt_data  input  WIDTH  rs value for MTHI/MTLO
read_hilo  input  1  MFHI/MFLO in decode this cycle
hi  output  WIDTH  HI register (remainder)
lo  output  WIDTH  LO register (quotient)
busy  output  1  divide in progress
done  output  1  one-cycle pulse when HI/LO receive a divide result
stall  output  1  combinational: busy & (start | mthi | mtlo | read_hilo)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0. Applies mid-divide: the operation is abandoned and HI/LO are not updated by it.
- FSM states and transitions:
  - IDLE: start -> PREP, latching operands and op_signed.
  - PREP: divisor==0 -> FIXUP; otherwise -> ITER, counter=WIDTH-1.
  - ITER: one quotient bit per cycle; counter==0 -> FIXUP.
  - FIXUP: -> IDLE.
- busy=1 in PREP, ITER and FIXUP.
- PREP (signed operations):
  - Take magnitudes of both operands.
  - Record q_neg = sign(dividend) XOR sign(divisor), and r_neg = sign(dividend).
  - Unsigned operations: q_neg = r_neg = 0.
- ITER step:
  - Shift {rem, quo} left 1.
  - trial = rem - |divisor| at WIDTH+1 bits.
  - If trial is non-negative: rem = trial, quo[0] = 1.
- FIXUP:
  - lo = q_neg ? -quo : quo; hi = r_neg ? -rem : rem.
  - done=1 for exactly the following cycle (registered, coincident with return to IDLE).
- Latency: start sampled at edge N gives hi/lo valid and done=1 after edge N+WIDTH+2 (34 cycles for WIDTH=32).
- Divide by zero: skips ITER. FIXUP writes hi = original dividend, lo = all-ones. Done follows edge N+2.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the magnitude algorithm and needs no special case.
- Requests while busy:
  - start, mthi, mtlo are ignored and stall=1.
  - The CPU holds the instruction until stall drops.
  - stall deasserts combinationally in the cycle busy falls, and the held request is accepted that cycle.
- In IDLE:
  - mthi and mtlo take effect at the next edge. Both in the same cycle update both registers.
  - mthi/mtlo together with start: the MT write lands now; the divide result overwrites HI/LO later.
- read_hilo in IDLE: no stall. hi/lo are driven directly from the registers (zero latency).
- clk_enable=0: holds state, counter, hi/lo and done. stall is still computed from held busy.

Test Plan:
- DIVU 0x0000004D / 0x0000000B -> after 34 cycles lo=0x00000007, hi=0x00000000; done high exactly one cycle; busy low afterwards.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same operands as DIVU -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU same operands -> lo=0, hi=0x80000000. DIVU 5/0 -> hi=5, lo=0xFFFFFFFF, done at cycle 2.
- Start a divide, assert read_hilo and mthi (mt_data=0x1234) at cycle 5 and hold them -> stall=1 until busy falls. hi ends as 0x1234 (mthi accepted after the result write). lo = quotient.
- Reset pulsed low during iteration 10 after MTLO set lo=0xAAAA -> busy=0, hi=lo=0 immediately (asynchronous); next DIVU 100/7 -> lo=14, hi=2.
- clk_enable low for 5 cycles mid-divide -> done arrives 5 cycles late with correct result; hi/lo unchanged while frozen.
